// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan receiver: the hex glyph table,
// the digit positions inside one scan frame and the frame FSM states.
package sevseg_pkg;

  // Active-high segment patterns in {g,f,e,d,c,b,a} order, indexed by hex value.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Position of each field in the 8-digit scan, by anode bit.
  localparam logic [2:0] SUIT_GLYPH = 3'd0;
  localparam logic [2:0] RANK_GLYPH = 3'd1;
  localparam logic [2:0] PAD_LO     = 3'd2;
  localparam logic [2:0] SUIT_ONES  = 3'd3;
  localparam logic [2:0] SUIT_TENS  = 3'd4;
  localparam logic [2:0] PAD_HI     = 3'd5;
  localparam logic [2:0] RANK_ONES  = 3'd6;
  localparam logic [2:0] RANK_TENS  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } frame_state_e;

endpackage

// File: rtl/sevseg_glyph_decode.sv
// Reverse lookup of a 7-bit active-high glyph into its hex value.
// A glyph that matches no table entry reports hit=0 and value=0.
module sevseg_glyph_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       hit,
  output logic [3:0] value
);

  // Table entries are unique, so at most one index can match.
  always_comb begin
    hit   = 1'b0;
    value = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (glyph == HEX_GLYPH[i]) begin
        hit   = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Loopback monitor for the 8-digit multiplexed seven-segment display.
// Samples the active-low anode/cathode pins, waits for each digit to settle,
// rebuilds one scan frame and reports it with a frame_valid or frame_error pulse.
// Optional feature macro SEVSEG_DECODE_CHECK_EN: when defined, a finished frame
// is additionally checked for "F" pad glyphs and decimal score glyphs, and a
// failing frame pulses frame_error and leaves the outputs untouched.
module seven_segment_decoder
  import sevseg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [6:0] cat_in,
  input  logic [7:0] an_in,
  output logic [6:0] suit_glyph,
  output logic [6:0] rank_glyph,
  output logic [6:0] suit_score,
  output logic [6:0] rank_score,
  output logic       frame_valid,
  output logic       frame_error
);

  localparam logic [15:0] ACCEPT_CNT = 16'(SETTLE_CYCLES - 1);

  // tens*10 + ones, saturated to the two-digit range.
  function automatic logic [6:0] combine_score(input logic [3:0] tens,
                                               input logic [3:0] ones);
    logic [7:0] t8;
    logic [7:0] sum;
    t8  = {4'd0, tens};
    sum = (t8 << 3) + (t8 << 1) + {4'd0, ones};
    return (sum > 8'd99) ? 7'd99 : sum[6:0];
  endfunction

  logic [7:0]   an_s1_q, an_s2_q;
  logic [6:0]   cat_s1_q, cat_s2_q;
  logic [15:0]  cnt_d, cnt_q;
  logic         lines_moving;
  logic [7:0]   sel;
  logic [6:0]   seg;
  logic         dwell_done, dig_acc, multi_acc;
  logic [2:0]   dig_idx;

  frame_state_e state_q;
  logic [2:0]   exp_digit_q;
  logic [6:0]   glyph_q [8];
  logic [6:0]   suit_glyph_q, rank_glyph_q, suit_score_q, rank_score_q;
  logic         frame_valid_q, frame_error_q;

  logic         so_hit, st_hit, ro_hit, rt_hit;
  logic [3:0]   so_val, st_val, ro_val, rt_val;
  logic [6:0]   suit_score_d, rank_score_d;
  logic         frame_ok;

  // Two-flop synchronizer; reset to the undriven (all lines high) state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      an_s1_q  <= 8'hFF;
      an_s2_q  <= 8'hFF;
      cat_s1_q <= 7'h7F;
      cat_s2_q <= 7'h7F;
    end else begin
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
      cat_s1_q <= cat_in;
      cat_s2_q <= cat_s1_q;
    end
  end

  // Settle counter: zero on the first cycle a new value reaches the second
  // stage, then counts the cycles that value has held, saturating so that a
  // long dwell passes the acceptance point exactly once.
  always_comb begin
    lines_moving = (an_s1_q != an_s2_q) || (cat_s1_q != cat_s2_q);
    cnt_d        = cnt_q;
    if (lines_moving) begin
      cnt_d = 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Settle counter register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Classify a settled dwell: gap (no anode), single digit, or multi-hot.
  always_comb begin
    sel        = ~an_s2_q;
    seg        = ~cat_s2_q;
    dwell_done = (cnt_q == ACCEPT_CNT);
    dig_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) dig_idx = 3'(i);
    end
    dig_acc   = dwell_done && (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    multi_acc = dwell_done && (sel != 8'd0) && ((sel & (sel - 8'd1)) != 8'd0);
  end

  sevseg_glyph_decode u_suit_ones (.glyph(glyph_q[SUIT_ONES]), .hit(so_hit), .value(so_val));
  sevseg_glyph_decode u_suit_tens (.glyph(glyph_q[SUIT_TENS]), .hit(st_hit), .value(st_val));
  sevseg_glyph_decode u_rank_ones (.glyph(glyph_q[RANK_ONES]), .hit(ro_hit), .value(ro_val));
  sevseg_glyph_decode u_rank_tens (.glyph(glyph_q[RANK_TENS]), .hit(rt_hit), .value(rt_val));

  // Scores from the captured digits and the end-of-frame acceptance check.
  always_comb begin
    suit_score_d = combine_score(st_hit ? st_val : 4'd0, so_hit ? so_val : 4'd0);
    rank_score_d = combine_score(rt_hit ? rt_val : 4'd0, ro_hit ? ro_val : 4'd0);
`ifdef SEVSEG_DECODE_CHECK_EN
    frame_ok = (glyph_q[PAD_LO] == HEX_GLYPH[15]) && (glyph_q[PAD_HI] == HEX_GLYPH[15]) &&
               so_hit && (so_val <= 4'd9) && st_hit && (st_val <= 4'd9) &&
               ro_hit && (ro_val <= 4'd9) && rt_hit && (rt_val <= 4'd9);
`else
    frame_ok = 1'b1;
`endif
  end

  // Frame FSM: collects digits 0..7 in order, then publishes the frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      exp_digit_q   <= 3'd0;
      glyph_q       <= '{default: 7'd0};
      suit_glyph_q  <= 7'd0;
      rank_glyph_q  <= 7'd0;
      suit_score_q  <= 7'd0;
      rank_score_q  <= 7'd0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dig_acc && (dig_idx == SUIT_GLYPH)) begin
            glyph_q[SUIT_GLYPH] <= seg;
            exp_digit_q         <= 3'd1;
            state_q             <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (multi_acc) begin
            frame_error_q <= 1'b1;
            state_q       <= IDLE;
          end else if (dig_acc) begin
            if (dig_idx == exp_digit_q) begin
              glyph_q[dig_idx] <= seg;
              exp_digit_q      <= exp_digit_q + 3'd1;
              if (dig_idx == RANK_TENS) state_q <= DONE;
            end else if (dig_idx == SUIT_GLYPH) begin
              // A fresh digit 0 abandons the partial frame and starts over.
              frame_error_q       <= 1'b1;
              glyph_q[SUIT_GLYPH] <= seg;
              exp_digit_q         <= 3'd1;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= IDLE;
            end
          end
        end
        DONE: begin
          if (frame_ok) begin
            suit_glyph_q  <= glyph_q[SUIT_GLYPH];
            rank_glyph_q  <= glyph_q[RANK_GLYPH];
            suit_score_q  <= suit_score_d;
            rank_score_q  <= rank_score_d;
            frame_valid_q <= 1'b1;
          end else begin
            frame_error_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign suit_glyph  = suit_glyph_q;
  assign rank_glyph  = rank_glyph_q;
  assign suit_score  = suit_score_q;
  assign rank_score  = rank_score_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: table of whole-frame scenarios, hand-built
// corner sequences and randomized frames against a run-length reference model.
module tb_seven_segment_decoder;

  localparam int S = 16;
  localparam logic [7:0] AN_IDLE  = 8'hFF;
  localparam logic [6:0] CAT_IDLE = 7'h7F;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [6:0] cat_in;
  logic [7:0] an_in;
  logic [6:0] suit_glyph, rank_glyph, suit_score, rank_score;
  logic       frame_valid, frame_error;

  seven_segment_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cat_in      (cat_in),
    .an_in       (an_in),
    .suit_glyph  (suit_glyph),
    .rank_glyph  (rank_glyph),
    .suit_score  (suit_score),
    .rank_score  (rank_score),
    .frame_valid (frame_valid),
    .frame_error (frame_error)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;
  int dut_valid_cnt = 0;
  int dut_err_cnt = 0;
  int dut_both_cnt = 0;

  always @(negedge clk_in) begin
    if (frame_valid) dut_valid_cnt++;
    if (frame_error) dut_err_cnt++;
    if (frame_valid && frame_error) dut_both_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic int value_of(input logic [6:0] g);
    for (int v = 0; v < 16; v++) if (seg_of(v) == g) return v;
    return -1;
  endfunction

  function automatic int score_of(input int t, input int o);
    int s;
    s = ((t < 0) ? 0 : t) * 10 + ((o < 0) ? 0 : o);
    return (s > 99) ? 99 : s;
  endfunction

  int         m_capturing, m_next, m_valid, m_err, m_ss, m_rs;
  logic [6:0] m_sg, m_rg;
  logic [6:0] m_cap [8];
  logic [14:0] pend_val;
  int          pend_len;

  task automatic model_reset();
    m_capturing = 0; m_next = 0;
    m_sg = 7'd0; m_rg = 7'd0; m_ss = 0; m_rs = 0;
    pend_val = {AN_IDLE, CAT_IDLE}; pend_len = 0;
  endtask

  task automatic model_frame_end();
    int v [8];
    bit ok;
    for (int i = 0; i < 8; i++) v[i] = value_of(m_cap[i]);
    ok = 1'b1;
`ifdef SEVSEG_DECODE_CHECK_EN
    if (m_cap[2] != seg_of(15) || m_cap[5] != seg_of(15)) ok = 1'b0;
    if (v[3] < 0 || v[3] > 9 || v[4] < 0 || v[4] > 9) ok = 1'b0;
    if (v[6] < 0 || v[6] > 9 || v[7] < 0 || v[7] > 9) ok = 1'b0;
`endif
    if (ok) begin
      m_valid++;
      m_sg = m_cap[0]; m_rg = m_cap[1];
      m_ss = score_of(v[4], v[3]);
      m_rs = score_of(v[7], v[6]);
    end else begin
      m_err++;
    end
  endtask

  // One settled dwell seen on the pins.
  task automatic model_dwell(input logic [7:0] an, input logic [6:0] cat);
    logic [7:0] sel;
    int d;
    sel = ~an;
    if ($countones(sel) == 0) return;
    if ($countones(sel) > 1) begin
      if (m_capturing != 0) begin m_err++; m_capturing = 0; end
      return;
    end
    d = $clog2(int'(sel));
    if (m_capturing == 0) begin
      if (d == 0) begin m_cap[0] = ~cat; m_next = 1; m_capturing = 1; end
    end else if (d == m_next) begin
      m_cap[d] = ~cat; m_next++;
      if (d == 7) begin model_frame_end(); m_capturing = 0; end
    end else if (d == 0) begin
      m_err++; m_cap[0] = ~cat; m_next = 1;
    end else begin
      m_err++; m_capturing = 0;
    end
  endtask

  task automatic model_flush();
    if (pend_len >= S) model_dwell(pend_val[14:7], pend_val[6:0]);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] an, input logic [6:0] cat, input int len);
    if ({an, cat} != pend_val) begin
      model_flush();
      pend_val = {an, cat};
      pend_len = 0;
    end
    an_in = an; cat_in = cat;
    repeat (len) @(negedge clk_in);
    pend_len += len;
  endtask

  task automatic drive_digit(input int d, input logic [6:0] glyph, input int len);
    logic [7:0] a;
    a = 8'd1 << d;
    drive(~a, ~glyph, len);
  endtask

  // mode: 0 clean, 1 digit 3 skipped, 2 pad 2 shows "0", 3 restart after digit 2,
  //       4 digit k skipped, 5 digit k replaced by two anodes, 6 digit k bad glyph
  task automatic drive_frame(input logic [6:0] sg, input logic [6:0] rg, input int ss,
                             input int rs, input int mode, input int k, input int dwell);
    logic [6:0] g [8];
    logic [7:0] a;
    g[0] = sg; g[1] = rg; g[2] = seg_of(15); g[3] = seg_of(ss % 10);
    g[4] = seg_of(ss / 10); g[5] = seg_of(15); g[6] = seg_of(rs % 10); g[7] = seg_of(rs / 10);
    if (mode == 2) g[2] = seg_of(0);
    if (mode == 6) g[k] = ($urandom_range(0, 1) == 0) ? seg_of(int'($urandom_range(10, 15)))
                                                      : 7'($urandom);
    if (mode == 3) for (int d = 0; d < 3; d++) drive_digit(d, g[d], dwell);
    for (int d = 0; d < 8; d++) begin
      if ((mode == 1 && d == 3) || (mode == 4 && d == k)) continue;
      if (mode == 5 && d == k) begin
        a = (8'd1 << d) | (8'd1 << ((d + 3) % 8));
        drive(~a, ~g[d], dwell);
      end else begin
        drive_digit(d, g[d], dwell);
      end
    end
  endtask

  task automatic settle_gap();
    drive(AN_IDLE, CAT_IDLE, 30);
    #2;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input int ss, input int rs,
                               input logic [6:0] sg, input logic [6:0] rg);
    check({tag, " suit_score"}, int'(suit_score), ss);
    check({tag, " rank_score"}, int'(rank_score), rs);
    check({tag, " suit_glyph"}, int'(suit_glyph), int'(sg));
    check({tag, " rank_glyph"}, int'(rank_glyph), int'(rg));
    check({tag, " valid_and_error_together"}, dut_both_cnt, 0);
  endtask

  typedef struct {
    logic [6:0] sg, rg;
    int ss, rs, mode, nfr, dwell;
    int dv, de, es, er;
    logic [6:0] esg, erg;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int v0, e0, mode, k;
    model_reset();
    m_valid = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_cap[i] = 7'd0;

    tbl[0] = '{7'h5C, 7'h77, 42, 7,  0, 2, 100, 2, 0, 42, 7,  7'h5C, 7'h77};
    tbl[1] = '{7'h06, 7'h5B, 99, 0,  0, 1, 30,  1, 0, 99, 0,  7'h06, 7'h5B};
    tbl[2] = '{7'h3F, 7'h3F, 13, 58, 1, 1, 30,  0, 1, 99, 0,  7'h06, 7'h5B};
    tbl[3] = '{7'h5C, 7'h77, 55, 21, 0, 1, 30,  1, 0, 55, 21, 7'h5C, 7'h77};
`ifdef SEVSEG_DECODE_CHECK_EN
    tbl[4] = '{7'h71, 7'h01, 8, 90,  2, 1, 30,  0, 1, 55, 21, 7'h5C, 7'h77};
`else
    tbl[4] = '{7'h71, 7'h01, 8, 90,  2, 1, 30,  1, 0, 8,  90, 7'h71, 7'h01};
`endif
    tbl[5] = '{7'h39, 7'h4F, 60, 3,  3, 1, 40,  1, 1, 60, 3,  7'h39, 7'h4F};

    // Reset state
    rst_in = 1'b1; an_in = AN_IDLE; cat_in = CAT_IDLE;
    repeat (3) @(negedge clk_in);
    #2;
    check_outputs("reset", 0, 0, 7'd0, 7'd0);
    check("reset frame_valid", int'(frame_valid), 0);
    check("reset frame_error", int'(frame_error), 0);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);

    // Table-driven frames
    for (int t = 0; t < 6; t++) begin
      v0 = dut_valid_cnt; e0 = dut_err_cnt;
      for (int f = 0; f < tbl[t].nfr; f++)
        drive_frame(tbl[t].sg, tbl[t].rg, tbl[t].ss, tbl[t].rs, tbl[t].mode, 0, tbl[t].dwell);
      settle_gap();
      check($sformatf("tbl%0d valid_pulses", t), dut_valid_cnt - v0, tbl[t].dv);
      check($sformatf("tbl%0d error_pulses", t), dut_err_cnt - e0, tbl[t].de);
      check_outputs($sformatf("tbl%0d", t), tbl[t].es, tbl[t].er, tbl[t].esg, tbl[t].erg);
    end

    // Short glitch to digit 5 early in the digit-2 dwell is invisible.
    v0 = dut_valid_cnt; e0 = dut_err_cnt;
    drive_digit(0, 7'h5C, 100); drive_digit(1, 7'h77, 100);
    drive_digit(2, seg_of(15), 2); drive_digit(5, seg_of(15), 10); drive_digit(2, seg_of(15), 88);
    drive_digit(3, seg_of(2), 100); drive_digit(4, seg_of(4), 100); drive_digit(5, seg_of(15), 100);
    drive_digit(6, seg_of(7), 100); drive_digit(7, seg_of(0), 100);
    settle_gap();
    check("glitch valid_pulses", dut_valid_cnt - v0, 1);
    check("glitch error_pulses", dut_err_cnt - e0, 0);
    check_outputs("glitch", 42, 7, 7'h5C, 7'h77);

    // Two anodes low for 50 cycles mid-frame.
    v0 = dut_valid_cnt; e0 = dut_err_cnt;
    drive_digit(0, 7'h06, 40); drive_digit(1, 7'h06, 40); drive_digit(2, seg_of(15), 40);
    drive(~8'b0001_1000, ~seg_of(3), 50);
    for (int d = 3; d < 8; d++) drive_digit(d, seg_of(1), 40);
    settle_gap();
    check("multihot valid_pulses", dut_valid_cnt - v0, 0);
    check("multihot error_pulses", dut_err_cnt - e0, 1);
    check_outputs("multihot", 42, 7, 7'h5C, 7'h77);

    // Reset after digit 5 is accepted, then a full frame.
    v0 = dut_valid_cnt; e0 = dut_err_cnt;
    for (int d = 0; d < 6; d++) drive_digit(d, seg_of(d), 40);
    an_in = AN_IDLE; cat_in = CAT_IDLE; rst_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_in);
    #2;
    check_outputs("midreset", 0, 0, 7'd0, 7'd0);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("midreset pulses", (dut_valid_cnt - v0) + (dut_err_cnt - e0), 0);
    drive_frame(7'h6D, 7'h7D, 12, 34, 0, 0, 40);
    settle_gap();
    check("after_reset valid_pulses", dut_valid_cnt - v0, 1);
    check_outputs("after_reset", 12, 34, 7'h6D, 7'h7D);

    // Randomized frames against the model.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        5: begin mode = 4; k = int'($urandom_range(0, 7)); end
        6: begin mode = 5; k = int'($urandom_range(0, 7)); end
        7: begin mode = 3; k = 0; end
        8: begin mode = 6; k = (($urandom_range(0, 1) == 0) ? 3 : 6) + int'($urandom_range(0, 1)); end
        9: begin mode = 2; k = 0; end
        default: begin mode = 0; k = 0; end
      endcase
      drive_frame(7'($urandom), 7'($urandom), int'($urandom_range(0, 99)),
                  int'($urandom_range(0, 99)), mode, k, int'($urandom_range(20, 60)));
      settle_gap();
      check($sformatf("rand%0d valid_total", n), dut_valid_cnt, m_valid);
      check($sformatf("rand%0d error_total", n), dut_err_cnt, m_err);
      check_outputs($sformatf("rand%0d", n), m_ss, m_rs, m_sg, m_rg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
